aes_dec_iter: RTL

Iterative, handshaked AES-128 decryption core. It is the parametrised successor to the fully unrolled decryptor. It expands the key once into a stored round-key table, then decrypts one block at a time, running UNROLL inverse rounds per clock, with valid/ready flow control on input and output. It sits between the block-buffer front end and the plaintext sink in the decryption path.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_inv_round.sv | 57 +++++
 rtl/aes_dec_iter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the iterative decryptor: GF(2^8) arithmetic, S-boxes,
// round constants and the controller state encoding.
package aes_pkg;

    typedef enum logic [2:0] {
        S_NOKEY = 3'd0,
        S_KEXP  = 3'd1,
        S_IDLE  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] rcon [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = gf_mul2(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey
// and, unless last_i is set, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = c;
        return {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    endfunction

    logic [127:0] ark_s;
    logic [127:0] mix_s;

    // Byte (row r, col c) sits at index 4c+r; row r is rotated right by r columns.
    always_comb begin
        ark_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark_s[127-8*(4*c+r) -: 8] =
                    inv_sbox(state_i[127-8*(4*((c-r+4)%4)+r) -: 8]) ^ rkey_i[127-8*(4*c+r) -: 8];
            end
        end
    end

    // Column-wise inverse mix
    always_comb begin
        mix_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            mix_s[127-32*c -: 32] = inv_mix_col(ark_s[127-32*c -: 32]);
        end
    end

    // Final round skips the column mix
    always_comb begin
        if (last_i) begin
            state_o = ark_s;
        end else begin
            state_o = mix_s;
        end
    end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor with stored round keys and valid/ready handshakes.
// Define AES_DEC_CBC_EN to add IV ports and CBC chaining on the output.
module aes_dec_iter
    import aes_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef AES_DEC_CBC_EN
    input  logic         iv_valid,
    input  logic [127:0] iv_in,
`endif
    output logic         busy
);

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   kcnt_q, kcnt_d;
    logic [3:0]   rc_q, rc_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_q, out_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];
    logic [127:0] rnd_s [0:UNROLL];
    logic [127:0] pt_s;
`ifdef AES_DEC_CBC_EN
    logic [127:0] chain_q, chain_d;
    logic [127:0] ct_q, ct_d;
`endif

    assign rnd_s[0] = st_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [3:0] ridx_s;
        assign ridx_s = rc_q - 4'(g);
        aes_inv_round u_round (
            .state_i (rnd_s[g]),
            .rkey_i  (rk_q[ridx_s]),
            .last_i  (ridx_s == 4'd0),
            .state_o (rnd_s[g+1])
        );
    end

`ifdef AES_DEC_CBC_EN
    assign pt_s = rnd_s[UNROLL] ^ chain_q;
`else
    assign pt_s = rnd_s[UNROLL];
`endif

    assign key_ready = (state_q == S_NOKEY) || (state_q == S_IDLE);
    // A simultaneous key offer takes priority over a ciphertext offer
    assign in_ready  = (state_q == S_IDLE) && !key_valid;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_KEXP) || (state_q == S_RUN);
    assign out_data  = out_q;

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        rc_d    = rc_q;
        st_d    = st_q;
        out_d   = out_q;
        rk_d    = rk_q;
`ifdef AES_DEC_CBC_EN
        chain_d = chain_q;
        ct_d    = ct_q;
        if (iv_valid && ((state_q == S_NOKEY) || (state_q == S_IDLE))) begin
            chain_d = iv_in;
        end else begin
            chain_d = chain_q;
        end
`endif
        case (state_q)
            S_NOKEY, S_IDLE: begin
                if (key_valid) begin
                    rk_d[0] = key_in;
                    kcnt_d  = 4'd1;
                    state_d = S_KEXP;
                end else if ((state_q == S_IDLE) && in_valid) begin
                    st_d    = in_data ^ rk_q[10];
                    rc_d    = 4'd9;
`ifdef AES_DEC_CBC_EN
                    ct_d    = in_data;
`endif
                    state_d = S_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            S_KEXP: begin
                rk_d[kcnt_q] = key_step(rk_q[kcnt_q - 4'd1], rcon[kcnt_q - 4'd1]);
                if (kcnt_q == 4'd10) begin
                    state_d = S_IDLE;
                end else begin
                    kcnt_d = kcnt_q + 4'd1;
                end
            end
            S_RUN: begin
                st_d = rnd_s[UNROLL];
                rc_d = rc_q - 4'(UNROLL);
                if (rc_q == 4'(UNROLL - 1)) begin
                    out_d   = pt_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
`ifdef AES_DEC_CBC_EN
                    chain_d = ct_q;
`endif
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_NOKEY;
            end
        endcase
    end

    // State and datapath registers; reset invalidates the key table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NOKEY;
            kcnt_q  <= 4'd0;
            rc_q    <= 4'd0;
            st_q    <= 128'h0;
            out_q   <= 128'h0;
            for (int i = 0; i < 11; i++) begin
                rk_q[i] <= 128'h0;
            end
`ifdef AES_DEC_CBC_EN
            chain_q <= 128'h0;
            ct_q    <= 128'h0;
`endif
        end else begin
            state_q <= state_d;
            kcnt_q  <= kcnt_d;
            rc_q    <= rc_d;
            st_q    <= st_d;
            out_q   <= out_d;
            rk_q    <= rk_d;
`ifdef AES_DEC_CBC_EN
            chain_q <= chain_d;
            ct_q    <= ct_d;
`endif
        end
    end

endmodule
